// File: rtl/power_seq_pkg.sv
// power_seq_pkg: shared state encoding, default timing constants and per-state control decode
package power_seq_pkg;

    localparam int STEP_CYCLES_DEF = 2;
    localparam int ACK_TIMEOUT_DEF = 64;

    typedef enum logic [3:0] {
        ON, PD_CLK, PD_ISO, PD_RST, PD_SW, OFF, PU_SW, PU_RST, PU_ISO
    } pwr_state_e;

    typedef struct packed {
        logic switch_n;
        logic iso_n;
        logic rst_n;
        logic clkgate_en_n;
    } pwr_ctrl_t;

    function automatic pwr_ctrl_t ctrl_of(pwr_state_e s);
        case (s)
            ON:              return 4'b0111;
            PD_CLK, PU_ISO:  return 4'b0110;
            PD_ISO, PU_RST:  return 4'b0010;
            PD_RST, PU_SW:   return 4'b0000;
            default:         return 4'b1000;
        endcase
    endfunction

endpackage

// File: rtl/power_seq_timer.sv
// power_seq_timer: saturating dwell/timeout counter, cleared on load, expires at a programmable limit
module power_seq_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         count,
    input  logic [W-1:0] limit,
    output logic         expire
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else if (load) cnt_q <= '0;
        else if (count && cnt_q != '1) cnt_q <= cnt_q + 1'b1;

    assign expire = cnt_q == limit;

endmodule

// File: rtl/power_domain_sequencer.sv
// power_domain_sequencer: Moore FSM sequencing clock gate, isolation, reset and power switch
// for one power domain, with registered outputs and a sticky switch-ack timeout.
module power_domain_sequencer
    import power_seq_pkg::*;
#(
    parameter int STEP_CYCLES = STEP_CYCLES_DEF,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic req_valid_i,
    input  logic req_on_i,
    output logic req_ready_o,
    input  logic switch_ack_ni,
    output logic switch_no,
    output logic iso_no,
    output logic rst_no,
    output logic clkgate_en_no,
    output logic done_o,
    output logic powered_o,
    output logic timeout_o
);

    localparam int CW = $clog2((STEP_CYCLES > ACK_TIMEOUT ? STEP_CYCLES : ACK_TIMEOUT) + 1);
    localparam logic [CW-1:0] STEP_LIM = CW'(STEP_CYCLES - 1);
    localparam logic [CW-1:0] ACK_LIM = CW'(ACK_TIMEOUT - 1);

    pwr_state_e state_q, state_d;
    pwr_ctrl_t  ctrl_q;
    logic       accept, in_sw, expire, done_d, timeout_d;

    assign accept = req_valid_i && (state_q == ON || state_q == OFF);
    assign in_sw  = state_q == PD_SW || state_q == PU_SW;

    power_seq_timer #(.W(CW)) u_timer (
        .clk    (clk_i),
        .rst_n  (rst_ni),
        .load   (state_d != state_q),
        .count  (1'b1),
        .limit  (in_sw ? ACK_LIM : STEP_LIM),
        .expire (expire)
    );

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            state_q     <= ON;
            ctrl_q      <= ctrl_of(ON);
            done_o      <= 1'b0;
            powered_o   <= 1'b1;
            timeout_o   <= 1'b0;
            req_ready_o <= 1'b1;
        end else begin
            state_q     <= state_d;
            ctrl_q      <= ctrl_of(state_d);
            done_o      <= done_d;
            powered_o   <= state_d == ON;
            timeout_o   <= timeout_d;
            req_ready_o <= state_d == ON || state_d == OFF;
        end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ON:      if (accept && !req_on_i) state_d = PD_CLK;
            PD_CLK:  if (expire) state_d = PD_ISO;
            PD_ISO:  if (expire) state_d = PD_RST;
            PD_RST:  if (expire) state_d = PD_SW;
            PD_SW:   if (switch_ack_ni) state_d = OFF;
            OFF:     if (accept && req_on_i) state_d = PU_SW;
            PU_SW:   if (!switch_ack_ni) state_d = PU_RST;
            PU_RST:  if (expire) state_d = PU_ISO;
            PU_ISO:  if (expire) state_d = ON;
            default: state_d = ON;
        endcase
    end

    // A request matching the current stable state completes without moving
    always_comb begin
        done_d = (accept && (req_on_i == (state_q == ON)))
              || (state_q == PD_SW && state_d == OFF)
              || (state_q == PU_ISO && state_d == ON);
        timeout_d = accept ? 1'b0
                  : timeout_o || (ACK_TIMEOUT != 0 && in_sw && expire && state_d == state_q);
    end

    assign {switch_no, iso_no, rst_no, clkgate_en_no} = ctrl_q;

endmodule

// File: tb/tb_power_domain_sequencer.sv
// tb_power_domain_sequencer: directed scenarios with a 15-cycle switch-ack emulator
module tb_power_domain_sequencer;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    logic req_valid_i = 1'b0;
    logic req_on_i = 1'b0;
    logic req_ready_o, switch_ack_ni, switch_no, iso_no, rst_no, clkgate_en_no;
    logic done_o, powered_o, timeout_o;
    logic ack_force = 1'b0;
    logic ack_val = 1'b0;
    logic [14:0] hist = '0;
    logic [3:0] ctrl;
    int checks = 0;
    int fails = 0;
    int n;

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) hist <= {hist[13:0], switch_no};
    assign switch_ack_ni = ack_force ? ack_val : hist[14];
    assign ctrl = {switch_no, iso_no, rst_no, clkgate_en_no};

    power_domain_sequencer #(.STEP_CYCLES(2), .ACK_TIMEOUT(8)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .req_valid_i   (req_valid_i),
        .req_on_i      (req_on_i),
        .req_ready_o   (req_ready_o),
        .switch_ack_ni (switch_ack_ni),
        .switch_no     (switch_no),
        .iso_no        (iso_no),
        .rst_no        (rst_no),
        .clkgate_en_no (clkgate_en_no),
        .done_o        (done_o),
        .powered_o     (powered_o),
        .timeout_o     (timeout_o)
    );

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset;
        rst_ni = 1'b0;
        tick;
        tick;
        checks++; if (ctrl !== 4'b0111) begin fails++; $display("FAIL reset_ctrl got=%b exp=0111", ctrl); end
        checks++; if ({done_o, powered_o, timeout_o, req_ready_o} !== 4'b0101) begin fails++; $display("FAIL reset_status got=%b exp=0101", {done_o, powered_o, timeout_o, req_ready_o}); end
        rst_ni = 1'b1;
        tick;
        checks++; if (ctrl !== 4'b0111 || done_o !== 1'b0) begin fails++; $display("FAIL reset_release got=%b done=%b exp=0111 done=0", ctrl, done_o); end
    endtask

    task automatic test_power_down;
        req_valid_i = 1'b1;
        req_on_i = 1'b0;
        tick;
        req_valid_i = 1'b0;
        checks++; if (ctrl !== 4'b0110) begin fails++; $display("FAIL pd_clk got=%b exp=0110", ctrl); end
        checks++; if ({done_o, powered_o, req_ready_o} !== 3'b000) begin fails++; $display("FAIL pd_status got=%b exp=000", {done_o, powered_o, req_ready_o}); end
        tick;
        checks++; if (ctrl !== 4'b0110) begin fails++; $display("FAIL pd_clk_dwell got=%b exp=0110", ctrl); end
        tick;
        checks++; if (ctrl !== 4'b0010) begin fails++; $display("FAIL pd_iso got=%b exp=0010", ctrl); end
        tick;
        tick;
        checks++; if (ctrl !== 4'b0000) begin fails++; $display("FAIL pd_rst got=%b exp=0000", ctrl); end
        tick;
        tick;
        checks++; if (ctrl !== 4'b1000 || req_ready_o !== 1'b0) begin fails++; $display("FAIL pd_sw got=%b ready=%b exp=1000 ready=0", ctrl, req_ready_o); end
        n = 0;
        while (done_o !== 1'b1 && n < 20) begin tick; n++; end
        checks++; if (done_o !== 1'b1 || n != 16) begin fails++; $display("FAIL pd_done_latency got=%0d done=%b exp=16 done=1", n, done_o); end
        checks++; if (ctrl !== 4'b1000 || {powered_o, timeout_o, req_ready_o} !== 3'b011) begin fails++; $display("FAIL off_state got=%b/%b exp=1000/011", ctrl, {powered_o, timeout_o, req_ready_o}); end
        tick;
        checks++; if (done_o !== 1'b0) begin fails++; $display("FAIL pd_done_width got=%b exp=0", done_o); end
    endtask

    task automatic test_power_up;
        req_valid_i = 1'b1;
        req_on_i = 1'b1;
        tick;
        req_valid_i = 1'b0;
        checks++; if (ctrl !== 4'b0000) begin fails++; $display("FAIL pu_sw got=%b exp=0000", ctrl); end
        checks++; if ({done_o, powered_o, timeout_o, req_ready_o} !== 4'b0000) begin fails++; $display("FAIL pu_status got=%b exp=0000", {done_o, powered_o, timeout_o, req_ready_o}); end
        repeat (7) tick;
        checks++; if ({timeout_o, rst_no} !== 2'b00) begin fails++; $display("FAIL pu_pre_timeout got=%b exp=00", {timeout_o, rst_no}); end
        tick;
        checks++; if (timeout_o !== 1'b1) begin fails++; $display("FAIL pu_timeout got=%b exp=1", timeout_o); end
        n = 0;
        while (rst_no !== 1'b1 && n < 20) begin tick; n++; end
        checks++; if (n != 8 || ctrl !== 4'b0010) begin fails++; $display("FAIL pu_rst got=%0d/%b exp=8/0010", n, ctrl); end
        tick;
        checks++; if (ctrl !== 4'b0010) begin fails++; $display("FAIL pu_rst_dwell got=%b exp=0010", ctrl); end
        tick;
        checks++; if (ctrl !== 4'b0110) begin fails++; $display("FAIL pu_iso got=%b exp=0110", ctrl); end
        tick;
        tick;
        checks++; if (ctrl !== 4'b0111 || {done_o, powered_o, timeout_o, req_ready_o} !== 4'b1111) begin fails++; $display("FAIL on_reached got=%b/%b exp=0111/1111", ctrl, {done_o, powered_o, timeout_o, req_ready_o}); end
        tick;
        checks++; if (done_o !== 1'b0) begin fails++; $display("FAIL pu_done_width got=%b exp=0", done_o); end
    endtask

    task automatic test_matching;
        req_valid_i = 1'b1;
        req_on_i = 1'b1;
        tick;
        req_valid_i = 1'b0;
        checks++; if (done_o !== 1'b1 || ctrl !== 4'b0111) begin fails++; $display("FAIL match_on got=%b/%b exp=1/0111", done_o, ctrl); end
        checks++; if ({powered_o, timeout_o, req_ready_o} !== 3'b101) begin fails++; $display("FAIL match_on_status got=%b exp=101", {powered_o, timeout_o, req_ready_o}); end
        tick;
        checks++; if (done_o !== 1'b0 || ctrl !== 4'b0111) begin fails++; $display("FAIL match_on_after got=%b/%b exp=0/0111", done_o, ctrl); end
    endtask

    task automatic test_ignore_and_abort;
        req_valid_i = 1'b1;
        req_on_i = 1'b0;
        tick;
        req_on_i = 1'b1;
        checks++; if (ctrl !== 4'b0110 || req_ready_o !== 1'b0) begin fails++; $display("FAIL ign_pd_clk got=%b ready=%b exp=0110 ready=0", ctrl, req_ready_o); end
        tick;
        tick;
        checks++; if (ctrl !== 4'b0010 || done_o !== 1'b0) begin fails++; $display("FAIL ign_pd_iso got=%b done=%b exp=0010 done=0", ctrl, done_o); end
        tick;
        tick;
        checks++; if (ctrl !== 4'b0000) begin fails++; $display("FAIL ign_pd_rst got=%b exp=0000", ctrl); end
        req_valid_i = 1'b0;
        rst_ni = 1'b0;
        #1;
        checks++; if (ctrl !== 4'b0111) begin fails++; $display("FAIL abort_ctrl got=%b exp=0111", ctrl); end
        checks++; if ({done_o, powered_o, timeout_o, req_ready_o} !== 4'b0101) begin fails++; $display("FAIL abort_status got=%b exp=0101", {done_o, powered_o, timeout_o, req_ready_o}); end
        #3;
        rst_ni = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick;
            checks++; if (done_o !== 1'b0 || ctrl !== 4'b0111) begin fails++; $display("FAIL abort_quiet cycle=%0d got=%b/%b exp=0/0111", i, done_o, ctrl); end
        end
    endtask

    task automatic test_timeout_stuck;
        ack_force = 1'b1;
        ack_val = 1'b0;
        req_valid_i = 1'b1;
        req_on_i = 1'b0;
        tick;
        req_valid_i = 1'b0;
        repeat (6) tick;
        checks++; if (ctrl !== 4'b1000 || timeout_o !== 1'b0) begin fails++; $display("FAIL to_pd_sw got=%b/%b exp=1000/0", ctrl, timeout_o); end
        repeat (7) tick;
        checks++; if (timeout_o !== 1'b0) begin fails++; $display("FAIL to_early got=%b exp=0", timeout_o); end
        tick;
        checks++; if (timeout_o !== 1'b1 || ctrl !== 4'b1000) begin fails++; $display("FAIL to_set got=%b/%b exp=1/1000", timeout_o, ctrl); end
        repeat (6) tick;
        checks++; if ({done_o, req_ready_o, timeout_o} !== 3'b001 || ctrl !== 4'b1000) begin fails++; $display("FAIL to_wait got=%b/%b exp=001/1000", {done_o, req_ready_o, timeout_o}, ctrl); end
        ack_val = 1'b1;
        tick;
        checks++; if ({done_o, req_ready_o, timeout_o} !== 3'b111 || ctrl !== 4'b1000) begin fails++; $display("FAIL to_off got=%b/%b exp=111/1000", {done_o, req_ready_o, timeout_o}, ctrl); end
        req_valid_i = 1'b1;
        req_on_i = 1'b0;
        tick;
        req_valid_i = 1'b0;
        checks++; if ({done_o, timeout_o, powered_o} !== 3'b100 || ctrl !== 4'b1000) begin fails++; $display("FAIL match_off got=%b/%b exp=100/1000", {done_o, timeout_o, powered_o}, ctrl); end
        tick;
        checks++; if (done_o !== 1'b0) begin fails++; $display("FAIL match_off_width got=%b exp=0", done_o); end
        req_valid_i = 1'b1;
        req_on_i = 1'b1;
        tick;
        req_valid_i = 1'b0;
        repeat (3) tick;
        checks++; if (ctrl !== 4'b0000) begin fails++; $display("FAIL pu_wait_ack got=%b exp=0000", ctrl); end
        ack_val = 1'b0;
        tick;
        checks++; if (ctrl !== 4'b0010) begin fails++; $display("FAIL pu_ack got=%b exp=0010", ctrl); end
        ack_force = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_power_down;
        test_power_up;
        test_matching;
        test_ignore_and_abort;
        test_timeout_stuck;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/power_domain_sequencer.md
POWER_DOMAIN_SEQUENCER -- requirements
Module: power_domain_sequencer

Interface
REQ-001 SHALL have parameter STEP_CYCLES, default 2: dwell cycles per sequencing step, minimum 1.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 64: cycles to wait for a switch ack before flagging timeout; 0 disables the timeout.
REQ-003 SHALL have ports:
- clk_i  input  1  clock; one clock.
- rst_ni  input  1  reset, asynchronous, active-low.
- req_valid_i  input  1  power request valid.
- req_on_i  input  1  requested target: 1 = on, 0 = off.
- req_ready_o  output  1  request accepted when req_valid_i && req_ready_o at a rising edge.
- switch_ack_ni  input  1  switch-cell ack, active-low (0 = powered).
- switch_no  output  1  power switch, active-low (0 = on).
- iso_no  output  1  isolation, active-low.
- rst_no  output  1  domain reset, active-low.
- clkgate_en_no  output  1  clock gate, active-low (0 = clock gated).
- done_o  output  1  one-cycle pulse on reaching a stable state after an accepted request.
- powered_o  output  1  1 in ON state only.
- timeout_o  output  1  sticky ack-timeout flag.

Function
REQ-004 SHALL implement a Moore FSM with states ON, PD_CLK, PD_ISO, PD_RST, PD_SW, OFF, PU_SW, PU_RST, PU_ISO; all outputs SHALL be registered.
REQ-005 Output values per state (switch_no, iso_no, rst_no, clkgate_en_no):
- ON 0,1,1,1; PD_CLK 0,1,1,0; PD_ISO 0,0,1,0; PD_RST 0,0,0,0; PD_SW 1,0,0,0; OFF 1,0,0,0.
- PU_SW 0,0,0,0; PU_RST 0,0,1,0; PU_ISO 0,1,1,0.
REQ-006 req_ready_o SHALL be 1 only in ON or OFF.
REQ-007 Accepted off-request in ON SHALL move to PD_CLK on the accepting edge.
REQ-008 Accepted on-request in OFF SHALL move to PU_SW on the accepting edge.
REQ-009 PD_CLK, PD_ISO, PD_RST, PU_RST and PU_ISO SHALL each last exactly STEP_CYCLES cycles.
REQ-010 Step sequences:
- PD_CLK→PD_ISO→PD_RST→PD_SW.
- PU_RST→PU_ISO→ON.
REQ-011 PD_SW SHALL go to OFF on the first edge sampling switch_ack_ni=1; PU_SW SHALL go to PU_RST on the first edge sampling switch_ack_ni=0.
REQ-012 An accepted request matching the current state (on in ON, off in OFF) SHALL cause no transition and SHALL pulse done_o in the next cycle.
REQ-013 done_o SHALL pulse for exactly one cycle in the first cycle of ON or OFF reached by a sequence.
REQ-014 req_valid_i while req_ready_o=0 SHALL be ignored, with no queuing.
REQ-015 In PD_SW/PU_SW, a cycle counter SHALL count wait cycles; when it reaches ACK_TIMEOUT (ACK_TIMEOUT≠0), timeout_o SHALL set and the FSM SHALL keep waiting.
REQ-016 timeout_o SHALL clear on the next accepted request.
REQ-017 The shared step/timeout counter SHALL be $clog2(max(STEP_CYCLES,ACK_TIMEOUT)+1) bits wide, SHALL saturate, and SHALL never wrap.
REQ-018 switch_ack_ni toggling outside PD_SW/PU_SW SHALL be ignored.

Reset
REQ-019 On rst_ni=0 the block SHALL asynchronously enter ON with switch_no=0, iso_no=1, rst_no=1, clkgate_en_no=1, done_o=0, powered_o=1, timeout_o=0, req_ready_o=1, counter=0.
REQ-020 Reset asserted mid-sequence SHALL abort the sequence immediately to the ON values, with no done_o pulse.

Structure
REQ-021 The state enum and default parameter constants SHALL live in shared package power_seq_pkg.
REQ-022 The dwell/timeout counter SHALL be a sub-module power_seq_timer (load, count, expire), instantiated once.

Verification
REQ-023 Use a bench ack emulator that returns switch_no as switch_ack_ni after 15 cycles. With STEP_CYCLES=2, an off-request SHALL produce:
- clkgate_en_no=0 one cycle after accept;
- iso_no=0 two cycles later;
- rst_no=0 two cycles after that;
- switch_no=1 two cycles after that;
- OFF with a done_o pulse within 24 cycles of accept.
REQ-024 In OFF, an on-request SHALL produce switch_no=0, then after the ack rst_no=1, 2 cycles later iso_no=1, 2 cycles later clkgate_en_no=1, powered_o=1, and a done_o pulse.
REQ-025 With ack stuck at 0 and ACK_TIMEOUT=8, an off-request SHALL set timeout_o 8 cycles into PD_SW; the FSM stays in PD_SW, then reaches OFF once ack rises.
REQ-026 req_valid_i held during a sequence SHALL be ignored; an on-request in ON SHALL pulse done_o 1 cycle later with outputs unchanged.
REQ-027 rst_ni pulsed low in PD_RST SHALL give the ON output values immediately, and no done_o pulse SHALL follow.
